pin_char_sink: RTL
==================

Name: pin_char_sink

Overview:
- Downstream consumer of the processor's `pin_out` word in hardware builds; replaces the simulation-only character dump.
- Decodes the pin protocol: pin 0 = char strobe, pin 1 = halt, pins 9..2 = char bits 7..0.
- Buffers captured characters in a FIFO and serialises them on an 8N1 UART TX line.
- Signals `done` once the processor has halted and every buffered character has left the wire.

Parameters:
- BITNESS, 16: width of the processor pin word; must be >= 10.
- FIFO_DEPTH, 16: character FIFO entries; power of 2, >= 2.
- CLKS_PER_BIT, 4: clk cycles per UART bit; >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pin_out_i  in  BITNESS  processor pin_out word, sampled every clk.
- tx  out  1  UART serial output, idle high.
- halted  out  1  sticky; processor asserted the halt pin.
- done  out  1  halted, FIFO empty and UART idle.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  characters currently buffered.

Behaviour:
- Reset (rst high at a rising edge): tx=1, halted=0, done=0, overflow=0, fifo_count=0, FSM=IDLE, FIFO pointers=0. Reset mid-frame aborts the frame; tx returns high on that edge.
- Capture: at an edge where pin_out_i[0]=1, pin_out_i[1]=0 and halted=0, push char {pin_out_i[9:2]}; char bit i = pin_out_i[i+2].
  - A strobe held high N cycles pushes N characters, one per cycle. No edge detection.
- Halt: at an edge where pin_out_i[1]=1, halted<=1 and stays set until rst.
  - Same-cycle strobe and halt: halt wins; that character is discarded and overflow is not set.
  - All strobes after halted=1 are ignored.
- FIFO full: a push is accepted if fifo_count<FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the char is dropped and overflow<=1 (sticky). Buffered data is never corrupted.
- Simultaneous push and pop: fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- UART FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: tx=1. If fifo_count!=0, pop into the shift register, go to START, tx<=0.
  - START: hold CLKS_PER_BIT cycles, then go to DATA with tx<=bit0.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. Then STOP (or PARITY).
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then return to IDLE.
  - Back-to-back characters: the IDLE->START pop happens on the edge that ends STOP, so the next start bit follows the stop bit with no idle gap.
- Latency: a char pushed at edge N into an empty FIFO with the FSM in IDLE drives tx low from edge N+1.
  - fifo_count is 1 for cycle N..N+1 only.
- Frame length is 10*CLKS_PER_BIT cycles (11* with parity).
- tx is registered (glitch-free).
- done is registered: done<=halted & fifo empty & FSM==IDLE & no pop this edge. Once set, it stays set until rst.
- Bits of pin_out_i at or above index 10 are ignored.

Optional Feature:
- Macro PIN_SINK_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent in the PARITY state for CLKS_PER_BIT cycles, between DATA and STOP. Frame is 11 bits.
- Undefined: PARITY state absent; frame is 8N1, 10 bits.

Test Plan:
- Reset, then pin_out_i=0 for 20 cycles -> tx=1, done=0, halted=0, fifo_count=0 throughout.
- One-cycle strobe with char 0x48 (pin_out_i=16'h0121), CLKS_PER_BIT=4 -> tx low from next edge for 4 cycles, then bits 0,0,0,1,0,0,1,0 at 4 cycles each, then high 4 cycles. Total 40 cycles.
- Strobe held 20 cycles with char 0x41, FIFO_DEPTH=16 -> 1 char popped at once plus 16 buffered, remaining pushes dropped. overflow=1. Exactly 17 frames of 0x41 on tx, back-to-back with no idle gap between frames.
- Send "Hi" then halt pin (pin_out_i=16'h0002) -> halted=1 next edge. done=1 only after the second frame's stop bit completes.
- Same-cycle strobe+halt (pin_out_i=16'h0107) -> halted=1, fifo_count stays 0, no frame on tx, overflow=0, done=1.
- Assert rst mid-DATA bit 3 -> next edge: tx=1, fifo_count=0, FSM IDLE. Subsequent strobe 0x55 transmits correctly (with PARITY_EN: parity bit 0).

Source files
------------

// File: rtl/pin_char_sink.sv
// -----------------------------------------------------------------------------
// pin_char_sink
//   Hardware consumer of the processor pin_out word. Decodes the pin protocol
//   (pin0 = char strobe, pin1 = halt, pins 9..2 = char bits 7..0), buffers
//   characters in a FIFO and serialises them as 8N1 UART on tx. done rises
//   once the processor halted and every buffered character has left the wire.
//
//   Optional feature: define PIN_SINK_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit (11-bit frame).
//
// Parameters
//   BITNESS       width of the pin word (>= 10)
//   FIFO_DEPTH    character FIFO entries (power of 2, >= 2)
//   CLKS_PER_BIT  clk cycles per UART bit (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   pin_out_i    processor pin word, sampled every clk
//   tx           UART serial output, idle high, registered
//   halted       sticky, halt pin seen
//   done         sticky, halted with FIFO empty and UART idle
//   overflow     sticky, a character was dropped on a full FIFO
//   fifo_count   characters currently buffered
// -----------------------------------------------------------------------------
module pin_char_sink #(
  parameter int BITNESS      = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BITNESS-1:0]          pin_out_i,
  output logic                        tx,
  output logic                        halted,
  output logic                        done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef PIN_SINK_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        r_state, w_state_nxt;
  logic          r_tx, w_tx_nxt;
  logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_data;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_halted, r_done, r_overflow;

  logic          w_bit_end, w_has_data, w_full;
  logic          w_strobe, w_push, w_drop, w_pop;
  logic [2:0]    w_bit_idx_inc;
  logic [7:0]    w_char;

  // Bits above the protocol field carry nothing for this sink.
  generate
    if (BITNESS > 10) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^pin_out_i[BITNESS-1:10];
    end
  endgenerate

  assign w_char        = pin_out_i[9:2];
  assign w_bit_end     = (r_clk_cnt == CLK_LAST);
  assign w_has_data    = (r_count != '0);
  assign w_full        = (r_count == DEPTH_C);
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // Halt on the same edge beats the strobe; a pop on the same edge frees a slot.
  assign w_strobe = pin_out_i[0] & ~pin_out_i[1] & ~r_halted;
  assign w_push   = w_strobe & (~w_full | w_pop);
  assign w_drop   = w_strobe & w_full & ~w_pop;

  // ---------------------------------------------------------------------------
  // UART FSM: next state, next tx and pop request
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        w_tx_nxt      = 1'b1;
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_data[0];
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef PIN_SINK_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = ^r_data;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_idx_nxt = w_bit_idx_inc;
            w_tx_nxt      = r_data[w_bit_idx_inc];
          end
        end
      end
`ifdef PIN_SINK_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Popping on the stop-ending edge keeps back-to-back frames gapless.
        if (w_bit_end) begin
          if (w_has_data) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_tx_nxt      = 1'b1;
        w_clk_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, FIFO control and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_halted   <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (pin_out_i[1]) r_halted   <= 1'b1;
      if (w_drop)       r_overflow <= 1'b1;
      if (r_halted && !w_has_data && r_state == S_IDLE && !w_pop)
        r_done <= 1'b1;
    end
  end

  // Storage needs no reset; pointers/count define what is valid. A full FIFO
  // with a same-edge pop reads the old entry before it is overwritten.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_char;
    if (w_pop)  r_data          <= r_mem[r_rd_ptr];
  end

  assign tx         = r_tx;
  assign halted     = r_halted;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule
